// File: rtl/cep_dout_path_mc.sv
// cep_dout_path_mc
// Multi-channel read-data (DOUT) path for CEP wrappers. Each channel carries
// protected memory data through a valid-qualified pipeline, checks even parity
// per subword, applies the READCLEAR zero bypass and strips parity. A shared
// sticky log records the first erroring channel-read, and a saturating counter
// counts erroring channel-reads.
//
// Ports
//   sysClk, sysRstN   clock, asynchronous active-low reset
//   rdValid           per-channel read valid
//   rdAddr            per-channel address tag, travels with the read
//   protPhysDout      per-channel protected data, subword layout {par,data}
//   bypass0s          per-subword force-to-zero (READCLEAR in flight)
//   protChkDisable    suppresses parity errors at the checker stage
//   errClr            clears error log, overflow and counter
//   doutValid         per-channel output valid
//   corrDout          per-channel data, parity stripped, bypass applied
//   parErr            per-subword parity error, zero when doutValid is low
//   errLogValid/Chan/Addr/Word  first-error log
//   errOverflow       an error arrived while the log was already occupied
//   errCount          saturating count of erroring channel-reads
module cep_dout_path_mc #(
  parameter int NUM_CHAN    = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WE      = 1,
  parameter int PIPE_STAGES = 1,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 8,
  localparam int PROT_W     = DATA_WIDTH + NUM_WE,
  localparam int CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                         sysClk,
  input  logic                         sysRstN,
  input  logic [NUM_CHAN-1:0]          rdValid,
  input  logic [NUM_CHAN*ADDR_W-1:0]   rdAddr,
  input  logic [NUM_CHAN*PROT_W-1:0]   protPhysDout,
  input  logic [NUM_CHAN*NUM_WE-1:0]   bypass0s,
  input  logic                         protChkDisable,
  input  logic                         errClr,
  output logic [NUM_CHAN-1:0]          doutValid,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] corrDout,
  output logic [NUM_CHAN*NUM_WE-1:0]   parErr,
  output logic                         errLogValid,
  output logic [CHAN_W-1:0]            errLogChan,
  output logic [ADDR_W-1:0]            errLogAddr,
  output logic [NUM_WE-1:0]            errLogWord,
  output logic                         errOverflow,
  output logic [CNT_W-1:0]             errCount
);

  localparam int SUB_W = DATA_WIDTH / NUM_WE;
  localparam int SUM_W = CNT_W + 4;

  // Stage 0 is the raw input; stage PIPE_STAGES feeds the checker.
  logic [NUM_CHAN-1:0]        stValid [0:PIPE_STAGES];
  logic [NUM_CHAN*PROT_W-1:0] stData  [0:PIPE_STAGES];
  logic [NUM_CHAN*ADDR_W-1:0] stAddr  [0:PIPE_STAGES];
  logic [NUM_CHAN*NUM_WE-1:0] stByp   [0:PIPE_STAGES];

  assign stValid[0] = rdValid;
  assign stData[0]  = protPhysDout;
  assign stAddr[0]  = rdAddr;
  assign stByp[0]   = bypass0s;

  // Pipeline stages: valid always advances, payload loads only for a valid
  // read on that channel so the last read's payload is held between reads.
  for (genvar s = 1; s <= PIPE_STAGES; s++) begin : gStage
    always_ff @(posedge sysClk or negedge sysRstN) begin
      if (!sysRstN) begin
        stValid[s] <= '0;
        stData[s]  <= '0;
        stAddr[s]  <= '0;
        stByp[s]   <= '0;
      end else begin
        stValid[s] <= stValid[s-1];
        for (int c = 0; c < NUM_CHAN; c++) begin
          if (stValid[s-1][c]) begin
            stData[s][c*PROT_W +: PROT_W] <= stData[s-1][c*PROT_W +: PROT_W];
            stAddr[s][c*ADDR_W +: ADDR_W] <= stAddr[s-1][c*ADDR_W +: ADDR_W];
            stByp[s][c*NUM_WE +: NUM_WE]  <= stByp[s-1][c*NUM_WE +: NUM_WE];
          end
        end
      end
    end
  end

  logic [NUM_CHAN-1:0]           chkValid;
  logic [NUM_CHAN*PROT_W-1:0]    chkData;
  logic [NUM_CHAN*ADDR_W-1:0]    chkAddr;
  logic [NUM_CHAN*NUM_WE-1:0]    chkByp;
  logic [NUM_CHAN*NUM_WE-1:0]    chkErr;
  logic [NUM_CHAN*NUM_WE-1:0]    chkErrQ;
  logic [NUM_CHAN*DATA_WIDTH-1:0] chkCorr;
  logic [NUM_CHAN-1:0]           errEvt;

  assign chkValid = stValid[PIPE_STAGES];
  assign chkData  = stData[PIPE_STAGES];
  assign chkAddr  = stAddr[PIPE_STAGES];
  assign chkByp   = stByp[PIPE_STAGES];

  // Checker: even parity over {par,data} per subword. Bypass zeroes the
  // output data only; the parity check still sees the real memory word.
  always_comb begin
    chkErr  = '0;
    chkErrQ = '0;
    chkCorr = '0;
    errEvt  = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      for (int k = 0; k < NUM_WE; k++) begin
        chkErr[c*NUM_WE+k] = (^chkData[c*PROT_W + (SUB_W+1)*k +: SUB_W+1]) & ~protChkDisable;
        chkCorr[c*DATA_WIDTH + SUB_W*k +: SUB_W] =
          chkData[c*PROT_W + (SUB_W+1)*k +: SUB_W] & ~{SUB_W{chkByp[c*NUM_WE+k]}};
      end
      chkErrQ[c*NUM_WE +: NUM_WE] = chkErr[c*NUM_WE +: NUM_WE] & {NUM_WE{chkValid[c]}};
      errEvt[c] = chkValid[c] & (|chkErr[c*NUM_WE +: NUM_WE]);
    end
  end

  logic                nextLogValid;
  logic [CHAN_W-1:0]   nextLogChan;
  logic [ADDR_W-1:0]   nextLogAddr;
  logic [NUM_WE-1:0]   nextLogWord;
  logic                nextOverflow;
  logic [CNT_W-1:0]    nextCount;
  logic [SUM_W-1:0]    numErr;
  logic [SUM_W-1:0]    sumCount;
  logic [CHAN_W-1:0]   capChan;
  logic [ADDR_W-1:0]   capAddr;
  logic [NUM_WE-1:0]   capWord;

  // Error log next state. errClr first empties the log, then this cycle's
  // events are applied on top, so a same-cycle error becomes a fresh capture.
  always_comb begin
    numErr  = '0;
    capChan = '0;
    capAddr = '0;
    capWord = '0;
    for (int c = NUM_CHAN - 1; c >= 0; c--) begin
      numErr = numErr + SUM_W'(errEvt[c]);
      if (errEvt[c]) begin
        capChan = CHAN_W'(c);
        capAddr = chkAddr[c*ADDR_W +: ADDR_W];
        capWord = chkErr[c*NUM_WE +: NUM_WE];
      end
    end

    nextLogValid = errClr ? 1'b0 : errLogValid;
    nextLogChan  = errClr ? '0 : errLogChan;
    nextLogAddr  = errClr ? '0 : errLogAddr;
    nextLogWord  = errClr ? '0 : errLogWord;
    nextOverflow = errClr ? 1'b0 : errOverflow;
    nextCount    = errClr ? '0 : errCount;

    sumCount = SUM_W'(nextCount) + numErr;
    if (sumCount > SUM_W'({CNT_W{1'b1}})) begin
      nextCount = {CNT_W{1'b1}};
    end else begin
      nextCount = sumCount[CNT_W-1:0];
    end

    if (numErr != '0) begin
      if (nextLogValid) begin
        nextOverflow = 1'b1;
      end else begin
        nextLogValid = 1'b1;
        nextLogChan  = capChan;
        nextLogAddr  = capAddr;
        nextLogWord  = capWord;
        if (numErr > SUM_W'(1)) begin
          nextOverflow = 1'b1;
        end
      end
    end
  end

  // Output stage and error log share one edge, so a logged error is visible
  // together with the doutValid of the read that caused it.
  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      doutValid   <= '0;
      corrDout    <= '0;
      parErr      <= '0;
      errLogValid <= 1'b0;
      errLogChan  <= '0;
      errLogAddr  <= '0;
      errLogWord  <= '0;
      errOverflow <= 1'b0;
      errCount    <= '0;
    end else begin
      doutValid <= chkValid;
      parErr    <= chkErrQ;
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (chkValid[c]) begin
          corrDout[c*DATA_WIDTH +: DATA_WIDTH] <= chkCorr[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      errLogValid <= nextLogValid;
      errLogChan  <= nextLogChan;
      errLogAddr  <= nextLogAddr;
      errLogWord  <= nextLogWord;
      errOverflow <= nextOverflow;
      errCount    <= nextCount;
    end
  end

endmodule
